sfr_bank: RTL and testbench
===========================

Name: sfr_bank

Overview:
- Parametrised bank of NREG special-function registers for the MCU51 core.
- Replaces single-register SFR instances with one addressed block.
- Software side: byte and bit read/write with a registered read port, a valid strobe and an error flag.
- Hardware side: per-bit set/clear inputs for peripheral status flags, plus per-register writable-bit masks and parallel register outputs for control fan-out.

Parameters:
- WIDTH, 8: register width in bits.
- NREG, 4: number of registers in the bank.
- ADDR_W, 2: address width; NREG <= 2**ADDR_W.
- BIT_W, 3: bit-index width; WIDTH <= 2**BIT_W.
- INITV, all zeros, NREG*WIDTH bits: reset value of each register. Register k occupies slice [k*WIDTH +: WIDTH].
- WMASK, all ones, NREG*WIDTH bits: software-writable bits. 0 means read-only to software; hardware set/clear still applies.
- RCMASK, all zeros, NREG*WIDTH bits: clear-on-read bits. Used only with SFR_RDCLR_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  software write strobe
- rd_en  in  1  software read strobe
- byte_mode  in  1  1 = byte access, 0 = bit access
- addr  in  ADDR_W  register select
- bitpos  in  BIT_W  bit index for bit access
- din  in  WIDTH  byte write data
- bin  in  1  bit write data
- dout  out  WIDTH  registered byte read data
- bout  out  1  registered bit read data
- rd_valid  out  1  read-data valid pulse
- rd_err  out  1  out-of-range read pulse
- hw_set  in  NREG*WIDTH  per-bit hardware set, level, sampled each cycle
- hw_clr  in  NREG*WIDTH  per-bit hardware clear
- regs_out  out  NREG*WIDTH  live register contents

Behaviour:
- Reset: asynchronous, active-high.
  - Registers load INITV.
  - dout=0, bout=0, rd_valid=0, rd_err=0.
  - regs_out=INITV immediately.
- Software byte write (wr_en & byte_mode): next = (cur & ~WMASK_k) | (din & WMASK_k).
- Software bit write (wr_en & ~byte_mode):
  - Bit bitpos takes bin only if WMASK_k[bitpos]=1.
  - Other bits hold.
  - bitpos >= WIDTH: write ignored.
- Per-bit priority within one cycle, highest first: hw_set, hw_clr, software write, (optional) read-clear, hold.
- Hardware set/clear acts on every register every cycle, independent of addr.
- Read: issued on rd_en, one-cycle latency.
  - At the next edge rd_valid=1 for exactly one cycle.
  - Byte mode: dout = register value before the edge; bout=0.
  - Bit mode: bout = that bit; dout=0.
  - dout and bout are 0 whenever rd_valid=0. There is no tristate output.
- Read and write to the same address in the same cycle: the read returns the pre-write value; the write takes effect.
- Back-to-back reads: one result per cycle, fully pipelined.
- Out-of-range (addr >= NREG or, in bit mode, bitpos >= WIDTH):
  - Writes are dropped.
  - Reads give rd_valid=1, rd_err=1, dout=0, bout=0.
- regs_out reflects the register state after each edge (registered, no combinational path from din).
- Reset asserted mid-read: the pending rd_valid is cancelled.

Optional Feature:
- Macro: SFR_RDCLR_EN.
- Defined:
  - A byte read of register k clears bits RCMASK_k at the same edge that captures dout. The captured value is pre-clear.
  - A bit read clears only the addressed bit, if it is set in RCMASK.
  - hw_set in the same cycle wins; a software write in the same cycle wins over read-clear.
  - Out-of-range reads clear nothing.
- Undefined: RCMASK is ignored; reads never modify state.

Test Plan:
- Reset with INITV reg1=8'hA5 -> regs_out reg1=8'hA5; dout=0, rd_valid=0 until the first read.
- WMASK reg0=8'h0F, byte write din=8'hFF to reg0=8'h00 -> reg0=8'h0F; read next cycle -> dout=8'h0F, rd_valid=1 for 1 cycle.
- Bit write bin=1 bitpos=7 on reg2=8'h00 -> 8'h80; bit read bitpos=7 -> bout=1; bitpos=6 -> bout=0.
- Same cycle: hw_set reg3 bit0, hw_clr reg3 bit1, byte write reg3 din=8'h02 -> reg3=8'h01.
- Read and write of addr 1 in the same cycle (old 8'h11, din 8'h22) -> dout=8'h11, next read 8'h22. With NREG=3, read addr=3 -> rd_err=1, dout=0.
- With SFR_RDCLR_EN and RCMASK reg0=8'h80, reg0=8'h81: read -> dout=8'h81, then reg0=8'h01. Repeat with hw_set bit7 in the same cycle -> reg0 stays 8'h81.

Source files
------------

// File: rtl/sfr_bank.sv
// Addressed bank of NREG special-function registers with byte/bit software access,
// per-bit hardware set/clear and a registered read port. Define SFR_RDCLR_EN for clear-on-read.
module sfr_bank #(
   parameter int WIDTH  = 8,
   parameter int NREG   = 4,
   parameter int ADDR_W = 2,
   parameter int BIT_W  = 3,
   parameter logic [NREG*WIDTH-1:0] INITV  = '0,
   parameter logic [NREG*WIDTH-1:0] WMASK  = '1,
   parameter logic [NREG*WIDTH-1:0] RCMASK = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  byte_mode,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [BIT_W-1:0]      bitpos,
   input  logic [WIDTH-1:0]      din,
   input  logic                  bin,
   output logic [WIDTH-1:0]      dout,
   output logic                  bout,
   output logic                  rd_valid,
   output logic                  rd_err,
   input  logic [NREG*WIDTH-1:0] hw_set,
   input  logic [NREG*WIDTH-1:0] hw_clr,
   output logic [NREG*WIDTH-1:0] regs_out
);

`ifdef SFR_RDCLR_EN
   localparam logic [NREG*WIDTH-1:0] RC_EFF = RCMASK;
`else
   // Feature off: no bit is clear-on-read.
   localparam logic [NREG*WIDTH-1:0] RC_EFF = RCMASK & {(NREG*WIDTH){1'b0}};
`endif

   logic [NREG*WIDTH-1:0] regs_d, regs_q;
   logic [WIDTH-1:0]      dout_d, dout_q;
   logic                  bout_d, bout_q;
   logic                  rd_valid_d, rd_valid_q;
   logic                  rd_err_d, rd_err_q;

   logic                  in_range;
   logic [WIDTH-1:0]      sel_reg;
   logic                  sel_bit;
   logic                  hit;
   logic                  bit_hit;

   always_comb begin
      regs_d  = regs_q;
      sel_reg = '0;
      sel_bit = 1'b0;
      hit     = 1'b0;
      bit_hit = 1'b0;
      in_range = ({1'b0, addr} < (ADDR_W+1)'(NREG)) &&
                 (byte_mode || ({1'b0, bitpos} < (BIT_W+1)'(WIDTH)));

      for (int k = 0; k < NREG; k++)
         if (addr == ADDR_W'(k)) sel_reg = regs_q[k*WIDTH +: WIDTH];
      for (int b = 0; b < WIDTH; b++)
         if (bitpos == BIT_W'(b)) sel_bit = sel_reg[b];

      // Apply sources lowest priority first so the later assignment wins per bit.
      for (int k = 0; k < NREG; k++) begin
         for (int b = 0; b < WIDTH; b++) begin
            hit     = in_range && (addr == ADDR_W'(k));
            bit_hit = hit && (byte_mode || (bitpos == BIT_W'(b)));
            if (rd_en && bit_hit && RC_EFF[k*WIDTH+b])
               regs_d[k*WIDTH+b] = 1'b0;
            if (wr_en && bit_hit && WMASK[k*WIDTH+b])
               regs_d[k*WIDTH+b] = byte_mode ? din[b] : bin;
            if (hw_clr[k*WIDTH+b]) regs_d[k*WIDTH+b] = 1'b0;
            if (hw_set[k*WIDTH+b]) regs_d[k*WIDTH+b] = 1'b1;
         end
      end

      rd_valid_d = rd_en;
      rd_err_d   = rd_en && !in_range;
      dout_d     = (rd_en && in_range && byte_mode) ? sel_reg : '0;
      bout_d     = rd_en && in_range && !byte_mode && sel_bit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q     <= INITV;
         dout_q     <= '0;
         bout_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         dout_q     <= dout_d;
         bout_q     <= bout_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign dout     = dout_q;
   assign bout     = bout_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign regs_out = regs_q;

endmodule

// File: tb/tb_sfr_bank.sv
// Scoreboard bench for sfr_bank: stimulus pushes expected read results, a negedge monitor pops them.
module tb_sfr_bank;
   localparam int WIDTH = 8, NREG = 4, ADDR_W = 3, BIT_W = 3;
   localparam logic [31:0] INITV  = 32'h0000_A500;
   localparam logic [31:0] WMASK  = 32'hFFFF_FF0F;
   localparam logic [31:0] RCMASK = 32'h0000_0080;
`ifdef SFR_RDCLR_EN
   localparam bit RDCLR = 1'b1;
`else
   localparam bit RDCLR = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1;
   logic wr_en = 0, rd_en = 0, byte_mode = 0, bin = 0;
   logic [ADDR_W-1:0] addr = '0;
   logic [BIT_W-1:0]  bitpos = '0;
   logic [WIDTH-1:0]  din = '0, dout;
   logic bout, rd_valid, rd_err;
   logic [31:0] hw_set = '0, hw_clr = '0, regs_out;

   int pass_cnt = 0, tot_cnt = 0;
   logic [9:0] exp_q[$];   // {err, dout[7:0], bout}
   bit done = 0;

   sfr_bank #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W), .BIT_W(BIT_W),
              .INITV(INITV), .WMASK(WMASK), .RCMASK(RCMASK)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .byte_mode(byte_mode),
      .addr(addr), .bitpos(bitpos), .din(din), .bin(bin), .dout(dout), .bout(bout),
      .rd_valid(rd_valid), .rd_err(rd_err), .hw_set(hw_set), .hw_clr(hw_clr),
      .regs_out(regs_out));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      wr_en = 0; rd_en = 0; hw_set = '0; hw_clr = '0;
   endtask

   task automatic rd_byte(input logic [ADDR_W-1:0] a, input logic e, input logic [7:0] d);
      rd_en = 1; byte_mode = 1; addr = a;
      exp_q.push_back({e, d, 1'b0});
   endtask

   task automatic rd_bit(input logic [ADDR_W-1:0] a, input logic [BIT_W-1:0] p, input logic v);
      rd_en = 1; byte_mode = 0; addr = a; bitpos = p;
      exp_q.push_back({1'b0, 8'h00, v});
   endtask

   // Monitor: every read result must match the oldest expectation; idle outputs must be zero.
   initial begin
      logic [9:0] e;
      while (!done) begin
         @(negedge clk);
         if (rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("read_result", {22'd0, rd_err, dout, bout}, {22'd0, e});
            end
         end else
            chk("idle_outputs_zero", {22'd0, rd_err, dout, bout}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 chk("reset_regs_out", regs_out, INITV);
      reset = 0;
      step();
      chk("after_reset_regs", regs_out, INITV);

      // Masked byte write, then read back.
      wr_en = 1; byte_mode = 1; addr = 0; din = 8'hFF; step(); idle();
      chk("wmask_byte_write", {24'd0, regs_out[7:0]}, 32'h0F);
      rd_byte(0, 0, 8'h0F); step(); idle(); step();

      // Bit write and back-to-back bit reads.
      wr_en = 1; byte_mode = 0; addr = 2; bitpos = 7; bin = 1; step(); idle();
      chk("bit_write", {24'd0, regs_out[23:16]}, 32'h80);
      rd_bit(2, 7, 1); step();
      rd_bit(2, 6, 0); step(); idle(); step();

      // hw_set beats hw_clr beats software write.
      hw_set[24] = 1; hw_clr[25] = 1;
      wr_en = 1; byte_mode = 1; addr = 3; din = 8'h02; step(); idle();
      chk("hw_priority", {24'd0, regs_out[31:24]}, 32'h01);
      step();
      chk("hw_level_released", {24'd0, regs_out[31:24]}, 32'h01);

      // Read and write of the same register in one cycle.
      wr_en = 1; byte_mode = 1; addr = 1; din = 8'h11; step(); idle();
      rd_byte(1, 0, 8'h11); wr_en = 1; din = 8'h22; step(); idle();
      rd_byte(1, 0, 8'h22); step(); idle();
      chk("rw_same_cycle_reg", {24'd0, regs_out[15:8]}, 32'h22);

      // Out-of-range access, back-to-back with a legal read.
      rd_byte(4, 1, 8'h00); step();
      rd_byte(2, 0, 8'h80); step();
      rd_bit(7, 3, 0); exp_q.pop_back(); exp_q.push_back({1'b1, 8'h00, 1'b0}); step(); idle();
      wr_en = 1; byte_mode = 1; addr = 5; din = 8'hAA; step(); idle();
      chk("oor_write_dropped", regs_out, 32'h0180_220F);

      // Clear-on-read of reg0 bit7.
      hw_clr[7:0] = 8'hFF; step(); idle();
      hw_set[7:0] = 8'h81; step(); idle();
      chk("reg0_preset", {24'd0, regs_out[7:0]}, 32'h81);
      rd_byte(0, 0, 8'h81); step(); idle();
      chk("rdclr_byte", {24'd0, regs_out[7:0]}, RDCLR ? 32'h01 : 32'h81);
      hw_set[7] = 1; step();
      rd_byte(0, 0, 8'h81); step(); idle();
      chk("rdclr_hw_set_wins", {24'd0, regs_out[7:0]}, 32'h81);
      rd_bit(0, 7, 1); step(); idle();
      chk("rdclr_bit", {24'd0, regs_out[7:0]}, RDCLR ? 32'h01 : 32'h81);
      step();

      // Reset during a pending read cancels it.
      rd_en = 1; byte_mode = 1; addr = 1;
      #2 reset = 1;
      @(posedge clk); #1 idle();
      chk("mid_read_reset_regs", regs_out, INITV);
      step(); reset = 0;
      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      done = 1;
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
